// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit-side blocks.
// DATA_BITS must match the transmitter's data-bit setting; FIFO_ADDR_W sets
// the default transmit buffer depth (2**FIFO_ADDR_W entries).
package uart_pkg;

   localparam int DATA_BITS   = 8;
   localparam int FIFO_ADDR_W = 4;

   // Transmit buffer sequencer: IDLE waits for data, ISSUE is the single
   // cycle where tx_start is high, WAIT holds t_data until tx_done.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } tx_buf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with an occupancy counter.
// full/empty are derived from the counter (not from pointer equality) and
// are registered alongside it; r_data shows the head entry combinationally.
// Writes while full and reads while empty are ignored.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int ADDR_W = FIFO_ADDR_W,
   parameter int DBIT   = DATA_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic              rd,
   input  logic [DBIT-1:0]   w_data,
   output logic [DBIT-1:0]   r_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ZERO_C  = (ADDR_W+1)'(0);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   logic [DBIT-1:0]   mem_q [DEPTH];
   logic [ADDR_W-1:0] wptr_q;
   logic [ADDR_W-1:0] rptr_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_d;
   logic              full_q;
   logic              empty_q;
   logic              wr_ok_s;
   logic              rd_ok_s;

   assign wr_ok_s = wr & ~full_q;
   assign rd_ok_s = rd & ~empty_q;

   // Next occupancy: a simultaneous accepted write and read leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({wr_ok_s, rd_ok_s})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents need no reset because reads are gated by count.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_q[wptr_q] <= w_data;
      end
   end

   // Pointers wrap modulo depth; flags are registered from the next count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= {ADDR_W{1'b0}};
         rptr_q  <= {ADDR_W{1'b0}};
         count_q <= ZERO_C;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (wr_ok_s) begin
            wptr_q <= wptr_q + ADDR_W'(1);
         end
         if (rd_ok_s) begin
            rptr_q <= rptr_q + ADDR_W'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         empty_q <= (count_d == ZERO_C);
      end
   end

   assign r_data = mem_q[rptr_q];
   assign full   = full_q;
   assign empty  = empty_q;
   assign count  = count_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: host-side transmit feeder. Bytes are queued in a FIFO and
// handed to the UART transmitter one at a time over tx_start/t_data/tx_done,
// with at most one character outstanding and zero gap between characters.
// Optional feature macro: UART_TX_BUF_OVERFLOW_EN adds a sticky 'overflow'
// output that records any write attempted while the FIFO was full.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int DBIT   = DATA_BITS,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DBIT-1:0]   wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              tx_start,
   output logic [DBIT-1:0]   t_data,
   input  logic              tx_done
`ifdef UART_TX_BUF_OVERFLOW_EN
   ,
   output logic              overflow
`endif
);

   tx_buf_state_t   state_q;
   logic            tx_start_q;
   logic [DBIT-1:0] t_data_q;
   logic [DBIT-1:0] head_s;
   logic            full_s;
   logic            empty_s;
   logic            pop_s;

   uart_sync_fifo #(
      .ADDR_W (ADDR_W),
      .DBIT   (DBIT)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr_en),
      .rd     (pop_s),
      .w_data (wr_data),
      .r_data (head_s),
      .full   (full_s),
      .empty  (empty_s),
      .count  (count)
   );

   // Pop the head exactly on the edge that enters ISSUE.
   always_comb begin
      pop_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty_s) pop_s = 1'b1;
            else          pop_s = 1'b0;
         end
         WAIT: begin
            if (tx_done && !empty_s) pop_s = 1'b1;
            else                     pop_s = 1'b0;
         end
         default: pop_s = 1'b0;
      endcase
   end

   // Issue sequencer with registered tx_start/t_data; tx_done is only heard in WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         t_data_q   <= {DBIT{1'b0}};
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!empty_s) begin
                  state_q    <= ISSUE;
                  tx_start_q <= 1'b1;
                  t_data_q   <= head_s;
               end else begin
                  state_q    <= IDLE;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  if (!empty_s) begin
                     state_q    <= ISSUE;
                     tx_start_q <= 1'b1;
                     t_data_q   <= head_s;
                  end else begin
                     state_q    <= IDLE;
                  end
               end else begin
                  state_q <= WAIT;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef UART_TX_BUF_OVERFLOW_EN
   logic overflow_q;

   // Sticky record of any write attempted while full; only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_q | (wr_en & full_s);
      end
   end

   assign overflow = overflow_q;
`endif

   assign full     = full_s;
   assign empty    = empty_s;
   assign tx_start = tx_start_q;
   assign t_data   = t_data_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed self-checking bench for uart_tx_buffer.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_uart_tx_buffer;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       tx_start;
   logic [7:0] t_data;
   logic       tx_done;
`ifdef UART_TX_BUF_OVERFLOW_EN
   logic       overflow;
`endif

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] got[$];
   int         max_cnt = 0;
   logic       prev_start = 1'b0;
   int         b2b_cnt = 0;
   int         base;

   uart_tx_buffer #(.DBIT(8), .ADDR_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .tx_start (tx_start),
      .t_data   (t_data),
      .tx_done  (tx_done)
`ifdef UART_TX_BUF_OVERFLOW_EN
      ,
      .overflow (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every issued byte, peak occupancy and any two-cycle tx_start.
   always @(posedge clk) begin
      if (tx_start) got.push_back(t_data);
      if (tx_start && prev_start) b2b_cnt <= b2b_cnt + 1;
      prev_start <= tx_start;
      if (int'(count) > max_cnt) max_cnt <= int'(count);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wr_burst(input logic [7:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = start + 8'(i);
         tick();
      end
      wr_en = 1'b0;
   endtask

   // Pulse tx_done every third cycle until 'target' bytes have been issued.
   task automatic drain(input int target);
      int guard;
      guard = 0;
      while (got.size() < target && guard < 500) begin
         tick();
         tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         guard++;
      end
      chk("drain_total", 32'(got.size()), 32'(target));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      tx_done = 1'b0;
      tick();
      tick();
      // Reset state
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_t_data",   32'(t_data),   32'd0);
      chk("rst_count",    32'(count),    32'd0);
      chk("rst_empty",    32'(empty),    32'd1);
      chk("rst_full",     32'(full),     32'd0);
`ifdef UART_TX_BUF_OVERFLOW_EN
      chk("rst_overflow", 32'(overflow), 32'd0);
`endif
      reset = 1'b0;
      tick();

      // Single byte: written at E0, issued for the cycle after E1
      base = got.size();
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      chk("single_cnt_e0",   32'(count),    32'd1);
      chk("single_start_e0", 32'(tx_start), 32'd0);
      tick();
      chk("single_start_e1", 32'(tx_start), 32'd1);
      chk("single_data_e1",  32'(t_data),   32'hA5);
      chk("single_cnt_e1",   32'(count),    32'd0);
      chk("single_empty_e1", 32'(empty),    32'd1);
      tick();
      chk("single_start_off", 32'(tx_start), 32'd0);
      repeat (5) tick();
      chk("single_hold_data", 32'(t_data), 32'hA5);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("single_no_reissue", 32'(tx_start), 32'd0);
      repeat (3) tick();
      chk("single_pulses", 32'(got.size() - base), 32'd1);

      // Burst 0x01..0x05, tx_done 20 cycles after each issue
      base = got.size();
      wr_burst(8'h01, 5);
      for (int k = 0; k < 5; k++) begin
         repeat (20) tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         if (k < 4) begin
            chk("burst_next_start", 32'(tx_start), 32'd1);
            chk("burst_next_data",  32'(t_data),   32'(k + 2));
         end else begin
            chk("burst_last_idle",  32'(tx_start), 32'd0);
         end
      end
      tick();
      chk("burst_pulses", 32'(got.size() - base), 32'd5);
      for (int k = 0; k < 5; k++) begin
         chk("burst_order", 32'(got[base + k]), 32'(k + 1));
      end

      // Full/drop: 18 writes with tx_done held low
      base = got.size();
      wr_burst(8'h10, 18);
      chk("full_count", 32'(count), 32'd16);
      chk("full_flag",  32'(full),  32'd1);
      chk("full_empty", 32'(empty), 32'd0);
      chk("full_data",  32'(t_data), 32'h10);
`ifdef UART_TX_BUF_OVERFLOW_EN
      chk("full_overflow", 32'(overflow), 32'd1);
`endif
      drain(base + 17);
      for (int k = 0; k < 17; k++) begin
         chk("full_order", 32'(got[base + k]), 32'h10 + 32'(k));
      end
      chk("full_after_cnt", 32'(count), 32'd0);
      do_reset();
`ifdef UART_TX_BUF_OVERFLOW_EN
      chk("overflow_cleared", 32'(overflow), 32'd0);
`endif

      // Wrap-around: 40 bytes in bursts of 13, 15, 12
      base = got.size();
      max_cnt = 0;
      wr_burst(8'h40, 13);
      drain(base + 13);
      wr_burst(8'h4D, 15);
      drain(base + 28);
      wr_burst(8'h5C, 12);
      drain(base + 40);
      for (int k = 0; k < 40; k++) begin
         chk("wrap_order", 32'(got[base + k]), 32'h40 + 32'(k));
      end
      chk("wrap_max_le16", 32'(max_cnt <= 16), 32'd1);
      chk("wrap_peak", 32'(max_cnt), 32'd14);

      // Simultaneous write and pop at count 3
      do_reset();
      base = got.size();
      wr_burst(8'hB0, 4);
      repeat (3) tick();
      chk("sim_pre_cnt", 32'(count), 32'd3);
      wr_en = 1'b1; wr_data = 8'hB4; tx_done = 1'b1;
      tick();
      wr_en = 1'b0; tx_done = 1'b0;
      chk("sim_cnt",   32'(count),    32'd3);
      chk("sim_start", 32'(tx_start), 32'd1);
      chk("sim_data",  32'(t_data),   32'hB1);
      drain(base + 5);
      chk("sim_order_1", 32'(got[base + 1]), 32'hB1);
      chk("sim_last",    32'(got[base + 4]), 32'hB4);

      // Reset mid-WAIT with 4 bytes queued
      do_reset();
      wr_burst(8'h60, 5);
      repeat (2) tick();
      chk("rstw_pre_cnt", 32'(count), 32'd4);
      #2;
      reset = 1'b1;
      #1;
      chk("rstw_start", 32'(tx_start), 32'd0);
      chk("rstw_count", 32'(count),    32'd0);
      chk("rstw_empty", 32'(empty),    32'd1);
      chk("rstw_data",  32'(t_data),   32'd0);
      base = got.size();
      tick();
      tick();
      reset = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (5) tick();
      chk("rstw_no_issue", 32'(got.size() - base), 32'd0);
      chk("rstw_cnt_after", 32'(count), 32'd0);

      chk("no_back_to_back_start", 32'(b2b_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
